// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, busywait fetch handshake and IF/ID register with stall skid buffer and redirect discard
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_read,
    input  logic [31:0] i_imem_readdata,
    input  logic        i_imem_busywait,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4_out,
    output logic [31:0] o_instruction,
    output logic        o_instr_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc, r_buf_instr, w_buf_instr, r_buf_pc, w_buf_pc, r_pending, w_pending;
    logic [31:0] r_pc_out, w_pc_out, r_pc4_out, w_pc4_out, r_instr, w_instr;
    logic        r_valid, w_valid;
    logic [31:0] w_target, w_pc4;
    logic        w_done;
    assign w_target = {i_branch_target[31:2], 2'b00};
    assign w_pc4    = r_pc + 32'd4;
    assign w_done   = !i_imem_busywait;
    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_buf_instr = r_buf_instr;
        w_buf_pc    = r_buf_pc;
        w_pending   = r_pending;
        w_pc_out    = r_pc_out;
        w_pc4_out   = r_pc4_out;
        w_instr     = r_instr;
        w_valid     = r_valid;
        case (r_state)
            FETCH: begin
                if (i_branch_taken) begin
                    w_instr = NOP_INSTR;
                    w_valid = 1'b0;
                    if (w_done) w_pc = w_target;
                    else begin
                        w_pending = w_target;
                        w_state   = DISCARD;
                    end
                end else if (i_stall) begin
                    if (w_done) begin
                        w_buf_instr = i_imem_readdata;
                        w_buf_pc    = r_pc;
                        w_pc        = w_pc4;
                        w_state     = HOLD;
                    end
                end else if (w_done) begin
                    w_pc_out  = r_pc;
                    w_pc4_out = w_pc4;
                    w_instr   = i_imem_readdata;
                    w_valid   = 1'b1;
                    w_pc      = w_pc4;
                end else begin
                    w_instr = NOP_INSTR;
                    w_valid = 1'b0;
                end
            end
            HOLD: begin
                if (i_branch_taken) begin
                    w_pc    = w_target;
                    w_instr = NOP_INSTR;
                    w_valid = 1'b0;
                    w_state = FETCH;
                end else if (!i_stall) begin
                    w_pc_out  = r_buf_pc;
                    w_pc4_out = r_buf_pc + 32'd4;
                    w_instr   = r_buf_instr;
                    w_valid   = 1'b1;
                    w_state   = FETCH;
                end
            end
            DISCARD: begin
                // The returned word belongs to the abandoned path; the newest redirect wins.
                if (i_branch_taken) w_pending = w_target;
                if (w_done) begin
                    w_pc    = i_branch_taken ? w_target : r_pending;
                    w_state = FETCH;
                end
            end
            default: w_state = FETCH;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_pending   <= '0;
            r_pc_out    <= RESET_PC;
            r_pc4_out   <= RESET_PC + 32'd4;
            r_instr     <= NOP_INSTR;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_buf_instr <= w_buf_instr;
            r_buf_pc    <= w_buf_pc;
            r_pending   <= w_pending;
            r_pc_out    <= w_pc_out;
            r_pc4_out   <= w_pc4_out;
            r_instr     <= w_instr;
            r_valid     <= w_valid;
        end
    end
    assign o_imem_addr    = r_pc;
    assign o_imem_read    = (r_state != HOLD);
    assign o_pc_out       = r_pc_out;
    assign o_pc_plus4_out = r_pc4_out;
    assign o_instruction  = r_instr;
    assign o_instr_valid  = r_valid;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus random traffic checked against a program-flow reference model
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst, stall, br, busy, read, valid;
    logic [31:0] tgt, addr, rdata, pc_out, pc4, instr;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_new = 0;
    logic        mdl_ok = 1'b0;
    logic [31:0] exp_next = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign rdata = mem_word(addr);

    instruction_fetch_unit dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_branch_taken(br), .i_branch_target(tgt),
        .o_imem_addr(addr), .o_imem_read(read), .i_imem_readdata(rdata), .i_imem_busywait(busy),
        .o_pc_out(pc_out), .o_pc_plus4_out(pc4), .o_instruction(instr), .o_instr_valid(valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock edge; the model tracks which PC the next fresh instruction must carry.
    task automatic tick();
        logic [31:0] p_pc, p_pc4, p_ins, p_addr, b_tgt;
        logic        p_val, p_read, b_rst, b_br, b_st, b_busy, new_v;
        p_pc = pc_out; p_pc4 = pc4; p_ins = instr; p_val = valid; p_addr = addr; p_read = read;
        b_rst = rst; b_br = br; b_st = stall; b_busy = busy; b_tgt = tgt;
        @(posedge clk);
        #1;
        if (b_rst) begin
            mdl_ok   = 1'b1;
            exp_next = 32'h0;
        end else if (mdl_ok) begin
            new_v = valid && !(p_val && pc_out == p_pc);
            if (p_read && b_busy) begin
                chk("addr_stable", addr, p_addr);
                chk("read_stable", read, 1);
            end
            if (b_br) begin
                chk("branch_bubble", valid, 0);
                exp_next = b_tgt & 32'hFFFF_FFFC;
            end else if (b_st) begin
                chk("stall_hold_pc", pc_out, p_pc);
                chk("stall_hold_pc4", pc4, p_pc4);
                chk("stall_hold_instr", instr, p_ins);
                chk("stall_hold_valid", valid, p_val);
            end else if (!p_read) begin
                chk("release_valid", valid, 1);
            end
            if (new_v) begin
                chk("flow_pc", pc_out, exp_next);
                chk("flow_instr", instr, mem_word(pc_out));
                exp_next = pc_out + 32'd4;
                n_new++;
            end
            if (!valid) chk("bubble_nop", instr, NOP);
            chk("plus4", pc4, pc_out + 32'd4);
        end
    endtask

    initial begin
        rst = 1; stall = 0; br = 0; tgt = 0; busy = 0;
        tick(); tick();
        chk("rst_pc", pc_out, 0);
        chk("rst_pc4", pc4, 4);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", valid, 0);
        chk("rst_read", read, 1);
        chk("rst_addr", addr, 0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_pc", pc_out, 32'(i * 4));
            chk("stream_valid", valid, 1);
        end
        rst = 1; tick(); rst = 0; tick(); tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_out, 4);
            chk("stall_read", read, 0);
        end
        stall = 0;
        tick();
        chk("rel_pc", pc_out, 8);
        chk("rel_valid", valid, 1);
        tick();
        chk("rel_pc2", pc_out, 12);
        rst = 1; tick(); rst = 0;
        for (int r = 0; r < 2; r++) begin
            busy = 1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("ws_bubble", valid, 0);
                chk("ws_addr", addr, 32'(r * 4));
            end
            busy = 0;
            tick();
            chk("ws_pc", pc_out, 32'(r * 4));
            chk("ws_valid", valid, 1);
        end
        busy = 1; br = 1; tgt = 32'h100;
        tick();
        chk("dis_bubble", valid, 0);
        chk("dis_addr", addr, 8);
        br = 0; tick();
        busy = 0; tick();
        chk("br_addr", addr, 32'h100);
        tick();
        chk("br_pc", pc_out, 32'h100);
        busy = 1; br = 1; tgt = 32'h180; tick();
        tgt = 32'h200; tick();
        br = 0; busy = 0; tick();
        chk("br2_addr", addr, 32'h200);
        chk("br2_valid", valid, 0);
        busy = 1; br = 1; tgt = 32'h300; tick();
        busy = 0; tgt = 32'h400; tick();
        br = 0;
        chk("same_cycle_addr", addr, 32'h400);
        tick();
        chk("same_cycle_pc", pc_out, 32'h400);
        stall = 1; br = 1; tgt = 32'h103; tick();
        chk("simul_addr", addr, 32'h100);
        chk("simul_valid", valid, 0);
        stall = 0; br = 0; tick();
        chk("simul_pc", pc_out, 32'h100);
        br = 1; tgt = 32'hFFFF_FFFC; tick();
        br = 0;
        chk("wrap_addr0", addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 0);
        chk("wrap_addr", addr, 0);
        busy = 1; br = 1; tgt = 32'h500; tick();
        br = 0; rst = 1; tick(); rst = 0;
        chk("rstd_pc", pc_out, 0);
        chk("rstd_pc4", pc4, 4);
        chk("rstd_instr", instr, NOP);
        chk("rstd_valid", valid, 0);
        chk("rstd_addr", addr, 0);
        chk("rstd_read", read, 1);
        busy = 0; tick();
        chk("rstd_first", pc_out, 0);
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 9) == 0);
            busy  = ($urandom_range(0, 2) == 0);
            tgt   = $urandom_range(0, 1023);
            tick();
        end
        rst = 0; stall = 0; br = 0; busy = 0;
        chk("liveness", 32'(n_new > 500), 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
